delay_path_checker: RTL and testbench

//   Capture-side monitor for a buffered flop-chain delay path.
//   On start, it counts clock edges until the chain output rises and reports the measured latency.
//   It checks that latency against an expected value and confirms the output then stays high.
//   It sits at the far end of the STA test chain and gives silicon/sim a pass/fail on chain depth.

---
 rtl/delay_path_checker.sv | 164 ++++++++++++++++
 tb/tb_delay_path_checker.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_path_checker.sv
// Capture-side monitor for a buffered flop-chain delay path.
// Measures start-to-arrival latency, checks it against EXP_LAT +/- TOL,
// then confirms path_q stays high for HOLD_CYC edges.
module delay_path_checker #(
    parameter int unsigned EXP_LAT  = 5,
    parameter int unsigned TOL      = 0,
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             path_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] lat_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_STUCK = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;
    localparam logic [1:0] ERR_LAT   = 2'd3;

    localparam logic [CNT_W-1:0] EXP_C  = CNT_W'(EXP_LAT);
    localparam logic [CNT_W-1:0] TOL_C  = CNT_W'(TOL);
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] TMO_C  = CNT_W'(TIMEOUT);

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] hcnt, hcnt_n;
    logic             busy_n, done_n, pass_n;
    logic [1:0]       err_n;
    logic [CNT_W-1:0] lat_n;

    // Edge index k of the current RUN edge and its distance from EXP_LAT
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] dev;
    logic [CNT_W-1:0] hcnt_inc;

    assign cnt_inc  = cnt + CNT_W'(1);
    assign hcnt_inc = hcnt + CNT_W'(1);
    assign dev      = (cnt_inc >= EXP_C) ? (cnt_inc - EXP_C) : (EXP_C - cnt_inc);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            hcnt     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_code <= ERR_OK;
            lat_o    <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            hcnt     <= hcnt_n;
            busy     <= busy_n;
            done     <= done_n;
            pass     <= pass_n;
            err_code <= err_n;
            lat_o    <= lat_n;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hcnt_n  = hcnt;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        err_n   = err_code;
        lat_n   = lat_o;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (path_q) begin
                        // Chain output never cleared: report stuck-high
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = 1'b0;
                        err_n   = ERR_STUCK;
                        lat_n   = '0;
                    end else begin
                        state_n = ST_RUN;
                        cnt_n   = '0;
                        busy_n  = 1'b1;
                        done_n  = 1'b0;
                        pass_n  = 1'b0;
                        err_n   = ERR_OK;
                        lat_n   = '0;
                    end
                end
            end
            ST_RUN: begin
                cnt_n = cnt_inc;
                if (path_q) begin
                    lat_n = cnt_inc;
                    if (dev <= TOL_C) begin
                        if (HOLD_C == '0) begin
                            state_n = ST_DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            pass_n  = 1'b1;
                            err_n   = ERR_OK;
                        end else begin
                            state_n = ST_HOLD;
                            hcnt_n  = '0;
                        end
                    end else begin
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = 1'b0;
                        err_n   = ERR_LAT;
                    end
                end else if (cnt_inc == TMO_C) begin
                    state_n = ST_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = 1'b0;
                    err_n   = ERR_TMO;
                    lat_n   = TMO_C;
                end
            end
            ST_HOLD: begin
                if (!path_q) begin
                    // Glitch after arrival
                    state_n = ST_DONE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = 1'b0;
                    err_n   = ERR_LAT;
                end else begin
                    hcnt_n = hcnt_inc;
                    if (hcnt_inc == HOLD_C) begin
                        state_n = ST_DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                        err_n   = ERR_OK;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_delay_path_checker.sv
// Bench for delay_path_checker: two instances (TOL=0 and TOL=1, TIMEOUT=20)
// share stimulus and are checked every cycle against a history-scanning model.
module tb_delay_path_checker;

    localparam int EXP  = 5;
    localparam int HOLD = 4;
    localparam int TMO  = 20;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic path_q;

    logic       a_busy, a_done, a_pass;
    logic [1:0] a_err;
    logic [7:0] a_lat;
    logic       b_busy, b_done, b_pass;
    logic [1:0] b_err;
    logic [7:0] b_lat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    delay_path_checker #(.EXP_LAT(EXP), .TOL(0), .HOLD_CYC(HOLD), .TIMEOUT(TMO), .CNT_W(8)) u_a (
        .clk(clk), .rst(rst), .start(start), .path_q(path_q),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_code(a_err), .lat_o(a_lat)
    );

    delay_path_checker #(.EXP_LAT(EXP), .TOL(1), .HOLD_CYC(HOLD), .TIMEOUT(TMO), .CNT_W(8)) u_b (
        .clk(clk), .rst(rst), .start(start), .path_q(path_q),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_code(b_err), .lat_o(b_lat)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keeps the sampled path_q history and, for an active measurement,
    // derives the result by scanning that history from the start edge.
    int tol_cfg [2] = '{0, 1};
    bit hist [0:8191];
    int t;
    int m_mode [2];   // 0 idle, 1 measuring, 2 reported
    int m_st   [2];
    int m_busy [2], m_done [2], m_pass [2], m_err [2], m_lat [2];

    task automatic m_finish(input int i, input int e, input int p, input int l);
        m_mode[i] = 2; m_busy[i] = 0; m_done[i] = 1;
        m_pass[i] = p; m_err[i] = e; m_lat[i] = l;
    endtask

    task automatic m_step(input int i);
        int a;
        int lat;
        int dv;
        bit gl;
        if (m_mode[i] != 1) begin
            if (start) begin
                if (path_q) m_finish(i, 1, 0, 0);
                else begin
                    m_mode[i] = 1; m_st[i] = t; m_busy[i] = 1; m_done[i] = 0;
                    m_pass[i] = 0; m_err[i] = 0; m_lat[i] = 0;
                end
            end
        end else begin
            a = -1;
            for (int j = m_st[i] + 1; j <= t; j++) if (hist[j] && a < 0) a = j;
            if (a < 0) begin
                if (t - m_st[i] == TMO) m_finish(i, 2, 0, TMO);
            end else begin
                lat = a - m_st[i];
                dv  = (lat > EXP) ? lat - EXP : EXP - lat;
                m_lat[i] = lat;
                if (dv > tol_cfg[i]) m_finish(i, 3, 0, lat);
                else begin
                    gl = 0;
                    for (int j = a + 1; j <= t; j++) if (!hist[j]) gl = 1;
                    if (gl) m_finish(i, 3, 0, lat);
                    else if (t - a == HOLD) m_finish(i, 0, 1, lat);
                end
            end
        end
    endtask

    // Model advances on every edge; reset clears it at once
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t = 0;
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = 0; m_st[i] = 0; m_busy[i] = 0; m_done[i] = 0;
                m_pass[i] = 0; m_err[i] = 0; m_lat[i] = 0;
            end
        end else begin
            if (t < 8191) t++;
            hist[t] = path_q;
            m_step(0);
            m_step(1);
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("a_busy", int'(a_busy), m_busy[0]);
            check("a_done", int'(a_done), m_done[0]);
            check("a_pass", int'(a_pass), m_pass[0]);
            check("a_err",  int'(a_err),  m_err[0]);
            check("a_lat",  int'(a_lat),  m_lat[0]);
            check("b_busy", int'(b_busy), m_busy[1]);
            check("b_done", int'(b_done), m_done[1]);
            check("b_pass", int'(b_pass), m_pass[1]);
            check("b_err",  int'(b_err),  m_err[1]);
            check("b_lat",  int'(b_lat),  m_lat[1]);
        end
    end

    // ---------------- stimulus ----------------
    // r_*[inst][c] = outputs seen just after edge N+c (N = start edge)
    int r_busy [2][64];
    int r_done [2][64];
    int r_pass [2][64];
    int r_err  [2][64];
    int r_lat  [2][64];

    task automatic record(input int c);
        r_busy[0][c] = int'(a_busy); r_done[0][c] = int'(a_done); r_pass[0][c] = int'(a_pass);
        r_err[0][c]  = int'(a_err);  r_lat[0][c]  = int'(a_lat);
        r_busy[1][c] = int'(b_busy); r_done[1][c] = int'(b_done); r_pass[1][c] = int'(b_pass);
        r_err[1][c]  = int'(b_err);  r_lat[1][c]  = int'(b_lat);
    endtask

    // path_q is 1 for edges N+rise .. N+fall-1; start at N, plus optional extra pulses
    task automatic run_seq(input int rise, input int fall, input int len,
                           input int rst_at, input bit pulses, input bit rnd);
        for (int c = 0; c < len; c++) begin
            start  = (c == 0) || (pulses && (c == 3 || c == 10)) ||
                     (rnd && c > 0 && $urandom_range(0, 9) == 0);
            path_q = (c >= rise) && (c < fall);
            @(posedge clk);
            #1;
            record(c);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", int'(a_busy), 0);
                check("rst_done", int'(a_done), 0);
                check("rst_pass", int'(a_pass), 0);
                check("rst_err",  int'(a_err),  0);
                check("rst_lat",  int'(a_lat),  0);
                rst = 1'b0;
                start = 1'b0;
                path_q = 1'b0;
                return;
            end
        end
        start  = 1'b0;
        path_q = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end by 1000000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; path_q = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(a_busy), 0);
        check("reset_done", int'(a_done), 0);
        check("reset_err",  int'(a_err),  0);
        check("reset_lat",  int'(a_lat),  0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Nominal arrival at N+5, held high
        run_seq(5, 1000, 12, -1, 0, 0);
        check("t1_lat5",   r_lat[0][5], 5);
        check("t1_busy1",  r_busy[0][1], 1);
        check("t1_busy8",  r_busy[0][8], 1);
        check("t1_done8",  r_done[0][8], 0);
        check("t1_done9",  r_done[0][9], 1);
        check("t1_pass9",  r_pass[0][9], 1);
        check("t1_err9",   r_err[0][9],  0);
        check("t1_busy9",  r_busy[0][9], 0);

        // Stuck-high at start
        run_seq(0, 1000, 4, -1, 0, 0);
        check("t2_done", r_done[0][0], 1);
        check("t2_err",  r_err[0][0],  1);
        check("t2_lat",  r_lat[0][0],  0);
        check("t2_pass", r_pass[0][0], 0);

        // Early arrival: fails with TOL=0, passes with TOL=1
        run_seq(4, 1000, 12, -1, 0, 0);
        check("t3_done", r_done[0][4], 1);
        check("t3_err",  r_err[0][4],  3);
        check("t3_lat",  r_lat[0][4],  4);
        check("t3_pass", r_pass[0][4], 0);
        check("t3b_pass", r_pass[1][8], 1);
        check("t3b_lat",  r_lat[1][8],  4);

        // Glitch after arrival
        run_seq(5, 7, 12, -1, 0, 0);
        check("t4_done6", r_done[0][6], 0);
        check("t4_done7", r_done[0][7], 1);
        check("t4_err7",  r_err[0][7],  3);
        check("t4_lat7",  r_lat[0][7],  5);

        // Timeout with start pulses during RUN
        run_seq(1000, 1000, 24, -1, 1, 0);
        check("t5_done19", r_done[0][19], 0);
        check("t5_busy19", r_busy[0][19], 1);
        check("t5_done20", r_done[0][20], 1);
        check("t5_err20",  r_err[0][20],  2);
        check("t5_lat20",  r_lat[0][20],  20);

        // Reset while in HOLD, then a fresh measurement
        run_seq(5, 1000, 12, 7, 0, 0);
        @(posedge clk); #1;
        run_seq(5, 1000, 12, -1, 0, 0);
        check("t6_lat",  r_lat[0][9],  5);
        check("t6_pass", r_pass[0][9], 1);

        // Randomized arrival/hold/restart sequences against the model
        for (int s = 0; s < 60; s++) begin
            int d;
            int h;
            d = int'($urandom_range(0, 25));
            h = int'($urandom_range(0, 8));
            run_seq(d, d + h, 30, -1, 0, 1);
        end

        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
